// File: rtl/keypad_event_ctrl.sv
// Keypad event controller: qualifies keypad scanner codes for stability and
// turns them into single-cycle press / release / auto-repeat events, plus
// decoded Pong paddle-step and game-control pulses.
module keypad_event_ctrl #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 2048,
  parameter int REPEAT_PERIOD = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] keycode,
  output logic       key_press,
  output logic       key_repeat,
  output logic       key_release,
  output logic [3:0] key_code_out,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start,
  output logic       pause
);

  localparam int MAX_AB = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [3:0] K_P1_UP   = 4'd1;
  localparam logic [3:0] K_P1_DOWN = 4'd4;
  localparam logic [3:0] K_P2_UP   = 4'd10;
  localparam logic [3:0] K_P2_DOWN = 4'd11;
  localparam logic [3:0] K_START   = 4'd14;
  localparam logic [3:0] K_PAUSE   = 4'd15;

  typedef enum logic [1:0] {IDLE, QUALIFY, HELD, REPEAT} state_t;

  state_t           state;
  logic [4:0]       in_q;
  logic [3:0]       code_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             key_valid;
  logic             code_chg;
  logic             paddle;
  logic             rpt_due;

  // Saturating increment so a long hold can never wrap back into a match.
  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_ONE;
  assign key_valid = in_q[0];
  assign code_chg  = in_q[4:1] != code_q;
  assign paddle    = (code_q == K_P1_UP) || (code_q == K_P1_DOWN) ||
                     (code_q == K_P2_UP) || (code_q == K_P2_DOWN);
  assign rpt_due   = (state == HELD)   ? (cnt == DELAY_LAST)  :
                     (state == REPEAT) ? (cnt == PERIOD_LAST) : 1'b0;

  // Input register: every decision below is made on the registered keycode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= keycode;
  end

  // Key FSM with registered event and decoded pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      code_q       <= '0;
      cnt          <= '0;
      key_press    <= 1'b0;
      key_repeat   <= 1'b0;
      key_release  <= 1'b0;
      key_code_out <= '0;
      p1_up        <= 1'b0;
      p1_down      <= 1'b0;
      p2_up        <= 1'b0;
      p2_down      <= 1'b0;
      start        <= 1'b0;
      pause        <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      p1_up       <= 1'b0;
      p1_down     <= 1'b0;
      p2_up       <= 1'b0;
      p2_down     <= 1'b0;
      start       <= 1'b0;
      pause       <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            state  <= QUALIFY;
            code_q <= in_q[4:1];
            cnt    <= CNT_ONE;
          end
        end
        QUALIFY: begin
          if (!key_valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (code_chg) begin
            code_q <= in_q[4:1];
            cnt    <= CNT_ONE;
          end else if (cnt == STABLE_LAST) begin
            state        <= HELD;
            cnt          <= '0;
            key_press    <= 1'b1;
            key_code_out <= code_q;
            p1_up        <= code_q == K_P1_UP;
            p1_down      <= code_q == K_P1_DOWN;
            p2_up        <= code_q == K_P2_UP;
            p2_down      <= code_q == K_P2_DOWN;
            start        <= code_q == K_START;
            pause        <= code_q == K_PAUSE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD, REPEAT: begin
          // Release / replacement outrank a repeat expiring in the same cycle.
          if (!key_valid) begin
            state       <= IDLE;
            cnt         <= '0;
            key_release <= 1'b1;
          end else if (code_chg) begin
            state       <= QUALIFY;
            code_q      <= in_q[4:1];
            cnt         <= CNT_ONE;
            key_release <= 1'b1;
          end else if (rpt_due) begin
            state      <= REPEAT;
            cnt        <= '0;
            key_repeat <= paddle;
            p1_up      <= code_q == K_P1_UP;
            p1_down    <= code_q == K_P1_DOWN;
            p2_up      <= code_q == K_P2_UP;
            p2_down    <= code_q == K_P2_DOWN;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl with STABLE/DELAY/PERIOD = 4/8/3.
// All nine pulse outputs are checked together each edge as one vector.
module tb_keypad_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] keycode = '0;
  logic       key_press, key_repeat, key_release;
  logic [3:0] key_code_out;
  logic       p1_up, p1_down, p2_up, p2_down, start, pause;

  int tests = 0;
  int fails = 0;

  localparam logic [8:0] PR  = 9'h100;
  localparam logic [8:0] RP  = 9'h080;
  localparam logic [8:0] RL  = 9'h040;
  localparam logic [8:0] P1U = 9'h020;
  localparam logic [8:0] P1D = 9'h010;
  localparam logic [8:0] P2U = 9'h008;
  localparam logic [8:0] P2D = 9'h004;
  localparam logic [8:0] ST  = 9'h002;
  localparam logic [8:0] PS  = 9'h001;

  logic [8:0] pv;
  assign pv = {key_press, key_repeat, key_release, p1_up, p1_down,
               p2_up, p2_down, start, pause};

  keypad_event_ctrl #(.STABLE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode),
    .key_press(key_press), .key_repeat(key_repeat), .key_release(key_release),
    .key_code_out(key_code_out),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start(start), .pause(pause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    keycode = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] exp;

    // Reset state
    do_reset();
    chk("rst_pulses", 32'(pv), 32'h0);
    chk("rst_code", 32'(key_code_out), 32'h0);

    // '1' held: press at edge 5, repeats at 13/16/19, release wins at 22
    keycode = {4'd1, 1'b1};
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = (e == 5) ? (PR | P1U) :
            (e == 13 || e == 16 || e == 19) ? (RP | P1U) : 9'h0;
      chk($sformatf("t1_e%0d", e), 32'(pv), 32'(exp));
      if (e == 5) chk("t1_code", 32'(key_code_out), 32'd1);
    end
    keycode = {4'd1, 1'b0};
    for (int e = 21; e <= 24; e++) begin
      tick();
      exp = (e == 22) ? RL : 9'h0;
      chk($sformatf("t1_rel_e%0d", e), 32'(pv), 32'(exp));
    end

    // '*' too short: no events at all
    do_reset();
    keycode = {4'd14, 1'b1};
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) keycode = {4'd14, 1'b0};
      chk($sformatf("t2_e%0d", e), 32'(pv), 32'h0);
    end
    chk("t2_code", 32'(key_code_out), 32'h0);

    // '#' held long: one press+pause, never a repeat, one release
    do_reset();
    keycode = {4'd15, 1'b1};
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp = (e == 5) ? (PR | PS) : 9'h0;
      chk($sformatf("t3_e%0d", e), 32'(pv), 32'(exp));
    end
    keycode = {4'd15, 1'b0};
    for (int e = 31; e <= 34; e++) begin
      tick();
      exp = (e == 32) ? RL : 9'h0;
      chk($sformatf("t3_rel_e%0d", e), 32'(pv), 32'(exp));
    end
    chk("t3_code", 32'(key_code_out), 32'd15);

    // 'A' then switch to 'B': release at 8, press+p2_down at 11
    do_reset();
    keycode = {4'd10, 1'b1};
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) keycode = {4'd11, 1'b1};
      exp = (e == 5) ? (PR | P2U) : (e == 8) ? RL : (e == 11) ? (PR | P2D) : 9'h0;
      chk($sformatf("t4_e%0d", e), 32'(pv), 32'(exp));
      if (e == 10) chk("t4_code_old", 32'(key_code_out), 32'd10);
      if (e == 11) chk("t4_code_new", 32'(key_code_out), 32'd11);
    end

    // '4' into repeat, async reset clears outputs, then fresh qualify
    do_reset();
    keycode = {4'd4, 1'b1};
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp = (e == 5) ? (PR | P1D) : (e == 13) ? (RP | P1D) : 9'h0;
      chk($sformatf("t5_e%0d", e), 32'(pv), 32'(exp));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_pulses", 32'(pv), 32'h0);
    chk("t5_async_code", 32'(key_code_out), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 5) ? (PR | P1D) : 9'h0;
      chk($sformatf("t5_re_e%0d", e), 32'(pv), 32'(exp));
    end
    chk("t5_re_code", 32'(key_code_out), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
- Consumes the 5-bit keycode bus from the keypad scanner: code in [4:1], press-valid in [0].
- Qualifies each key for stability and emits single-cycle press, release and auto-repeat events.
- Decodes the Pong control keys into per-player paddle step pulses and game-control pulses.
- Sits between the keypad scanner and the game logic / paddle position registers.

Parameters:
STABLE_CYCLES, 16, consecutive cycles a valid, unchanged code must be held before a press is accepted (>=2)
REPEAT_DELAY, 2048, cycles after an accepted press before the first auto-repeat (>=2)
REPEAT_PERIOD, 512, cycles between subsequent auto-repeats (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
keycode  input  5  [4:1] key code 0..15, [0]=1 key pressed
key_press  output  1  one-cycle pulse on accepted press
key_repeat  output  1  one-cycle pulse on each auto-repeat (paddle keys only)
key_release  output  1  one-cycle pulse when an accepted key is released or replaced
key_code_out  output  4  code of the currently/last accepted key, held until the next accepted press
p1_up  output  1  pulse on press/repeat of '1' (code 1)
p1_down  output  1  pulse on press/repeat of '4' (code 4)
p2_up  output  1  pulse on press/repeat of 'A' (code 10)
p2_down  output  1  pulse on press/repeat of 'B' (code 11)
start  output  1  pulse on press of '*' (code 14), no repeat
pause  output  1  pulse on press of '#' (code 15), no repeat

Behaviour:
- keycode is registered once (in_q) on entry. All decisions use in_q.
- Reset (rst_n=0, async): state=IDLE, counter=0, latched code=0, all outputs 0, key_code_out=0. Deassertion takes effect at the next clk edge. Reset mid-press discards the press; no release pulse is issued.
- Counter width is $clog2 of max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1. The counter saturates and never wraps.
- FSM states: IDLE, QUALIFY, HELD, REPEAT.
- IDLE:
  - in_q[0]=1 -> QUALIFY; latch in_q[4:1]; counter=1.
- QUALIFY:
  - in_q[0]=0 -> IDLE, no event.
  - in_q[0]=1 with a code different from the latch -> stay in QUALIFY; latch the new code; counter=1.
  - counter==STABLE_CYCLES-1 with same code -> HELD; counter=0; key_press=1 next cycle; key_code_out updated in the same cycle as key_press.
  - Otherwise counter+1.
- HELD:
  - in_q[0]=0 -> IDLE; key_release=1.
  - Code changed -> QUALIFY with the new code; counter=1; key_release=1 for the old key.
  - counter==REPEAT_DELAY-1 -> REPEAT; counter=0; key_repeat=1 if the latched code is a paddle key.
- REPEAT:
  - Release and change behave as in HELD.
  - counter==REPEAT_PERIOD-1 -> counter=0; key_repeat pulse (paddle keys only).
- Release and change take priority over repeat-counter expiry when they occur in the same cycle.
- Mapped outputs are pulses asserted in the same cycle as key_press or key_repeat when key_code_out matches. start and pause fire on key_press only. Unmapped keys produce only key_press and key_release.
- All pulse outputs are exactly one cycle wide, registered, and mutually exclusive per cycle, except that a mapped pulse accompanies key_press or key_repeat.
- Latency: key_press is high on the (STABLE_CYCLES+1)th rising edge after the first edge that samples keycode[0]=1, counting the input register.

Test Plan:
- Params 4/8/3. Reset, keycode={1,1} held 20 cycles -> key_press+p1_up once at edge 5, key_code_out=1; key_repeat+p1_up at edge 13, then every 3 cycles.
- keycode={14,1} held 3 cycles then {14,0} -> no key_press, no key_release, outputs stay 0.
- keycode={15,1} held 30 cycles -> single key_press+pause, no key_repeat; on release -> one key_release, key_code_out stays 15.
- Hold {10,1} past acceptance, switch to {11,1} -> key_release in the switch cycle+1, then key_press+p2_down 4 cycles later, key_code_out=11.
- Hold {4,1} into REPEAT, pull rst_n low mid-period -> all outputs 0 immediately, no pulse; after rst_n high with key still held -> fresh qualify, key_press at edge 5.
- Release {4,0} on the same cycle the repeat counter expires -> key_release only, no key_repeat, no p1_down.
